mnist_axis_feeder: RTL



---
 rtl/mnist_feeder_pkg.sv | 15 +
 rtl/mnist_axis_feeder_if.sv | 12 +
 rtl/feeder_pixel_ram.sv | 32 +++
 rtl/mnist_axis_feeder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mnist_feeder_pkg.sv
// Shared definitions for the MNIST AXI-Stream frame feeder: FSM encoding and the
// default frame geometry (matches the network's dataWidth / numWeightLayer1).
package mnist_feeder_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_PIXELS = 784;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

endpackage

// File: rtl/mnist_axis_feeder_if.sv
// AXI-Stream pixel channel between the feeder (master) and the network input (slave).
interface mnist_axis_feeder_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/feeder_pixel_ram.sv
// Frame buffer: simple dual-port RAM, synchronous write, 1-cycle synchronous read,
// write-first on a same-address collision.
module feeder_pixel_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 784
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: the pixel array deliberately has no reset so it maps onto block RAM
    // and keeps the loaded frame across resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mnist_axis_feeder.sv
// Streams a buffered MNIST frame as an AXI-Stream master through a 2-entry FIFO.
// Optional build macro MNIST_FEEDER_FRAME_COUNT_EN adds the frames_sent counter.
module mnist_axis_feeder
    import mnist_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
`ifdef MNIST_FEEDER_FRAME_COUNT_EN
    output logic [15:0]           frames_sent,
`endif
    mnist_axis_feeder_if.master   m_axis
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic                  rd_vld_q;
    logic                  rd_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  wr_idx_q;
    logic                  rd_idx_q;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  wr_err_q;
`ifdef MNIST_FEEDER_FRAME_COUNT_EN
    logic [15:0]           frames_q;
`endif

    logic                  tvalid;
    logic                  pop;
    logic                  wr_ok;
    logic                  issue;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] ram_rdata;

    feeder_pixel_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (NUM_PIXELS)
    ) u_ram (
        .clk   (s_axi_aclk),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (issue),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign tvalid = (cnt_q != 2'd0);
    assign pop    = tvalid && m_axis.tready;

    // A read may only launch if the FIFO still has a free slot once both the
    // in-flight read lands and this cycle's pop (if any) has happened.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ok = 1'b0;
        issue = 1'b0;
        occ   = {1'b0, cnt_q} + {2'b0, rd_vld_q} - {2'b0, pop};
        cnt_d = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
        if (state_q == ST_IDLE) begin
            wr_ok = wr_en && (wr_addr <= LAST_ADDR);
            issue = start;
        end else if (state_q == ST_STREAM) begin
            issue = (occ <= 3'd1);
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q        <= ST_IDLE;
            rd_ptr_q       <= '0;
            rd_vld_q       <= 1'b0;
            rd_last_q      <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= 2'b00;
            wr_idx_q       <= 1'b0;
            rd_idx_q       <= 1'b0;
            cnt_q          <= 2'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            wr_err_q       <= 1'b0;
`ifdef MNIST_FEEDER_FRAME_COUNT_EN
            frames_q       <= 16'd0;
`endif
        end else begin
            wr_err_q  <= wr_en && !wr_ok;
            done_q    <= 1'b0;
            rd_vld_q  <= issue;
            rd_last_q <= issue && (rd_ptr_q == LAST_ADDR);
            cnt_q     <= cnt_d;

            if (issue && (rd_ptr_q != LAST_ADDR)) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (rd_vld_q) begin
                fifo_data_q[wr_idx_q] <= ram_rdata;
                fifo_last_q[wr_idx_q] <= rd_last_q;
                wr_idx_q              <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_STREAM;
                        busy_q  <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (issue && (rd_ptr_q == LAST_ADDR)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_last_q[rd_idx_q]) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        rd_ptr_q <= '0;
`ifdef MNIST_FEEDER_FRAME_COUNT_EN
                        frames_q <= frames_q + 16'd1;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = fifo_data_q[rd_idx_q];
    assign m_axis.tlast  = tvalid && fifo_last_q[rd_idx_q];
    assign busy          = busy_q;
    assign done          = done_q;
    assign wr_err        = wr_err_q;
`ifdef MNIST_FEEDER_FRAME_COUNT_EN
    assign frames_sent   = frames_q;
`endif

endmodule
